meanfilter_win: RTL and testbench

- True sliding-window mean filter for time-grating position samples.
- Keeps the last 2^WIN_LOG2 samples in a circular buffer and a running sum updated as sum + new - oldest. Output is one sample per input sample, not one per window.
- Generalises meanfitler:
  - window depth is a parameter;
  - wrap-around (0/full-scale crossing) detection is selectable;
  - adds explicit reset, warm-up priming and output valid.
- Sits between the grating sample front end and the position/velocity path.

---
 rtl/meanfilter_pkg.sv | 11 +
 rtl/meanfilter_win_if.sv | 14 +
 rtl/meanfilter_win_buf.sv | 26 ++
 rtl/meanfilter_win.sv | 52 +++++
 tb/tb_meanfilter_win.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/meanfilter_pkg.sv
// meanfilter_pkg: shared state type, depth helper and crossline detector for the mean filter.
package meanfilter_pkg;
   typedef enum logic {PRIME, RUN} state_t;
   localparam int WIN_LOG2_DEF = 3;
   function automatic int depth(input int win_log2);
      return 1 << win_log2;
   endfunction
   function automatic logic crossline(input logic [1:0] prev_top2, input logic [1:0] new_top2);
      return (prev_top2 == 2'b11 && new_top2 == 2'b00) || (prev_top2 == 2'b00 && new_top2 == 2'b11);
   endfunction
endpackage

// File: rtl/meanfilter_win_if.sv
// meanfilter_win_if: sample-in / window-sum-out bundle of the mean filter.
interface meanfilter_win_if #(
   parameter int DATA_WIDTH = 24,
   parameter int WIN_LOG2 = 3
);
   logic en;
   logic iValid;
   logic [DATA_WIDTH-1:0] iData;
   logic [DATA_WIDTH+WIN_LOG2-1:0] oData;
   logic [DATA_WIDTH-1:0] oMean;
   logic oValid;
   modport master(output en, iValid, iData, input oData, oMean, oValid);
   modport slave(input en, iValid, iData, output oData, oMean, oValid);
endinterface

// File: rtl/meanfilter_win_buf.sv
// meanfilter_win_buf: circular sample buffer with single-cycle fill of every entry.
module meanfilter_win_buf import meanfilter_pkg::*; #(
   parameter int DATA_WIDTH = 24,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  fill_all,
   input  logic                  adv,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int N = depth(WIN_LOG2);
   logic [DATA_WIDTH-1:0] mem [N];
   logic [WIN_LOG2-1:0] ptr;
   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else if (adv) ptr <= ptr + 1'b1;
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (wr_en && (fill_all || ptr == WIN_LOG2'(i))) mem[i] <= wr_data;
   end
   assign rd_data = mem[ptr];
endmodule

// File: rtl/meanfilter_win.sv
// meanfilter_win: sliding-window mean of the last 2^WIN_LOG2 samples, one output per input sample.
module meanfilter_win import meanfilter_pkg::*; #(
   parameter int DATA_WIDTH = 24,
   parameter int WIN_LOG2 = WIN_LOG2_DEF,
   parameter bit WRAP_EN = 1'b1
) (
   input logic clk,
   input logic rst,
   meanfilter_win_if.slave bus
);
   localparam int SW = DATA_WIDTH + WIN_LOG2;
   state_t state, state_nx;
   logic acc, flush, wr_en, adv, valid;
   logic [1:0] last_top, new_top;
   logic [DATA_WIDTH-1:0] oldest;
   logic [SW-1:0] sum, sum_nx;
   assign acc = bus.iValid && !rst;
   assign new_top = bus.iData[DATA_WIDTH-1 -: 2];
   always_ff @(posedge clk) begin
      if (rst) state <= PRIME;
      else state <= state_nx;
   end
   always_comb state_nx = !acc ? state : bus.en ? RUN : PRIME;
   // crossline is judged against the last accepted sample, so last_top only moves on accept
   always_comb begin
      flush = state == PRIME || (WRAP_EN && crossline(last_top, new_top));
      wr_en = acc && bus.en;
      adv = wr_en && !flush;
      sum_nx = (!bus.en || flush) ? {bus.iData, WIN_LOG2'(0)}
                                  : sum + SW'(bus.iData) - SW'(oldest);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
         valid <= 1'b0;
         last_top <= 2'b00;
      end else begin
         valid <= bus.iValid;
         if (bus.iValid) begin
            sum <= sum_nx;
            last_top <= new_top;
         end
      end
   end
   meanfilter_win_buf #(.DATA_WIDTH(DATA_WIDTH), .WIN_LOG2(WIN_LOG2)) u_buf (
      .clk(clk), .rst(rst), .wr_en(wr_en), .fill_all(flush), .adv(adv),
      .wr_data(bus.iData), .rd_data(oldest)
   );
   assign bus.oData = sum;
   assign bus.oMean = sum[SW-1:WIN_LOG2];
   assign bus.oValid = valid;
endmodule

// File: tb/tb_meanfilter_win.sv
// tb_meanfilter_win: directed vectors on a wrapping and a non-wrapping 8-bit, 4-deep filter.
module tb_meanfilter_win;
   localparam int DW = 8;
   localparam int WL = 2;
   typedef struct {
      logic       r;
      logic       e;
      logic [7:0] d;
      logic [9:0] ew;
      logic [9:0] ep;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b1;
   logic iv = 1'b0;
   logic [7:0] din = '0;
   int n_cmp = 0;
   int n_bad = 0;
   int vcnt = 0;
   vec_t tbl[17];
   logic [7:0] mdl[2][4];
   logic prime[2];
   logic [1:0] lt[2];
   logic [9:0] ex[2];
   always #5 clk = ~clk;
   meanfilter_win_if #(.DATA_WIDTH(DW), .WIN_LOG2(WL)) w_if();
   meanfilter_win_if #(.DATA_WIDTH(DW), .WIN_LOG2(WL)) p_if();
   assign w_if.en = en;
   assign w_if.iValid = iv;
   assign w_if.iData = din;
   assign p_if.en = en;
   assign p_if.iValid = iv;
   assign p_if.iData = din;
   meanfilter_win #(.DATA_WIDTH(DW), .WIN_LOG2(WL), .WRAP_EN(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(w_if));
   meanfilter_win #(.DATA_WIDTH(DW), .WIN_LOG2(WL), .WRAP_EN(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(p_if));
   always @(negedge clk) if (w_if.oValid) vcnt++;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic check_all(input logic [9:0] ew, input logic [9:0] ep, input logic v);
      chk("wrap oValid", 32'(w_if.oValid), 32'(v));
      chk("plain oValid", 32'(p_if.oValid), 32'(v));
      chk("wrap oData", 32'(w_if.oData), 32'(ew));
      chk("plain oData", 32'(p_if.oData), 32'(ep));
      chk("wrap oMean", 32'(w_if.oMean), 32'(ew[9:2]));
      chk("plain oMean", 32'(p_if.oMean), 32'(ep[9:2]));
   endtask
   task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
      rst = r;
      en = e;
      iv = v;
      din = d;
      @(posedge clk);
      #1;
      rst = 1'b0;
      iv = 1'b0;
   endtask
   task automatic model(input logic [7:0] d);
      for (int m = 0; m < 2; m++) begin
         if (prime[m] || (m == 0 && ((lt[m] == 2'b11 && d[7:6] == 2'b00) || (lt[m] == 2'b00 && d[7:6] == 2'b11))))
            for (int j = 0; j < 4; j++) mdl[m][j] = d;
         else begin
            for (int j = 0; j < 3; j++) mdl[m][j] = mdl[m][j+1];
            mdl[m][3] = d;
         end
         prime[m] = 1'b0;
         lt[m] = d[7:6];
         ex[m] = '0;
         for (int j = 0; j < 4; j++) ex[m] += 10'(mdl[m][j]);
      end
   endtask
   initial begin
      int acc_cnt;
      int v0;
      tbl = '{
         '{1'b1, 1'b1, 8'h00, 10'd0,   10'd0},
         '{1'b0, 1'b1, 8'd10, 10'd40,  10'd40},
         '{1'b0, 1'b1, 8'd20, 10'd50,  10'd50},
         '{1'b0, 1'b1, 8'd30, 10'd70,  10'd70},
         '{1'b0, 1'b1, 8'd40, 10'd100, 10'd100},
         '{1'b0, 1'b1, 8'd50, 10'd140, 10'd140},
         '{1'b1, 1'b1, 8'h77, 10'd0,   10'd0},
         '{1'b0, 1'b1, 8'h08, 10'h020, 10'h020},
         '{1'b1, 1'b1, 8'h00, 10'd0,   10'd0},
         '{1'b0, 1'b1, 8'hF0, 10'h3C0, 10'h3C0},
         '{1'b0, 1'b1, 8'hF0, 10'h3C0, 10'h3C0},
         '{1'b0, 1'b1, 8'hF0, 10'h3C0, 10'h3C0},
         '{1'b0, 1'b1, 8'hF0, 10'h3C0, 10'h3C0},
         '{1'b0, 1'b1, 8'h05, 10'h014, 10'h2D5},
         '{1'b0, 1'b1, 8'h09, 10'h018, 10'h1EE},
         '{1'b0, 1'b0, 8'h33, 10'h0CC, 10'h0CC},
         '{1'b0, 1'b1, 8'h10, 10'h040, 10'h040}
      };
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check_all(10'd0, 10'd0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].r, tbl[i].e, 1'b1, tbl[i].d);
         check_all(tbl[i].ew, tbl[i].ep, !tbl[i].r);
      end
      // idle cycles hold the output; data seen without iValid must not count as last sample
      step(1'b1, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'hF0);
      check_all(10'h3C0, 10'h3C0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h05);
         check_all(10'h3C0, 10'h3C0, 1'b0);
      end
      step(1'b0, 1'b1, 1'b1, 8'h0C);
      check_all(10'h030, 10'h2DC, 1'b1);
      step(1'b0, 1'b1, 1'b0, 8'hFF);
      step(1'b0, 1'b1, 1'b1, 8'hC8);
      check_all(10'h320, 10'h2B4, 1'b1);
      // full-rate and gapped traffic against a shift-register window model
      step(1'b1, 1'b1, 1'b0, 8'h00);
      prime = '{1'b1, 1'b1};
      lt = '{2'b00, 2'b00};
      acc_cnt = 0;
      v0 = vcnt;
      for (int k = 0; k < 30; k++) begin
         logic [7:0] d;
         int gap;
         gap = k < 6 ? 0 : (k - 6) % 6;
         d = 8'($urandom_range(0, 255));
         model(d);
         step(1'b0, 1'b1, 1'b1, d);
         acc_cnt++;
         check_all(ex[0], ex[1], 1'b1);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            chk("idle wrap oValid", 32'(w_if.oValid), 32'd0);
            chk("idle wrap hold", 32'(w_if.oData), 32'(ex[0]));
         end
      end
      @(negedge clk);
      chk("oValid count", 32'(vcnt - v0), 32'(acc_cnt));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
